// File: rtl/snake_pkg.sv
// Shared direction codes, reversal helper and PS/2 scan codes for the snake direction controller.
package snake_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_UP    = 3'd1;
    localparam dir_t DIR_RIGHT = 3'd2;
    localparam dir_t DIR_DOWN  = 3'd3;
    localparam dir_t DIR_LEFT  = 3'd4;
    localparam dir_t DIR_NONE  = 3'd5;

    localparam logic [7:0] PS2_KEY_W     = 8'h1D;
    localparam logic [7:0] PS2_KEY_D     = 8'h23;
    localparam logic [7:0] PS2_KEY_S     = 8'h1B;
    localparam logic [7:0] PS2_KEY_A     = 8'h1C;
    localparam logic [7:0] PS2_KEY_I     = 8'h43;
    localparam logic [7:0] PS2_KEY_L     = 8'h4B;
    localparam logic [7:0] PS2_KEY_K     = 8'h42;
    localparam logic [7:0] PS2_KEY_J     = 8'h3B;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;

    function automatic dir_t dir_reverse(input dir_t dir);
        dir_t rev;
        rev = DIR_NONE;
        case (dir)
            DIR_UP:    rev = DIR_DOWN;
            DIR_RIGHT: rev = DIR_LEFT;
            DIR_DOWN:  rev = DIR_UP;
            DIR_LEFT:  rev = DIR_RIGHT;
            default:   rev = DIR_NONE;
        endcase
        return rev;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and a registered rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            // Counter only advances while the synchronised level disagrees with the accepted one.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Multi-player direction controller: debounced presses, reversal rejection, commit on game tick.
// Optional PS/2 keyboard input is enabled by defining SNAKE_PS2_DIR_EN.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 5000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4*NUM_PLAYERS-1:0] btn,
    input  logic                     pause,
`ifdef SNAKE_PS2_DIR_EN
    input  logic                     ps2_key_pressed,
    input  logic [7:0]               ps2_out,
`endif
    output logic                     tick,
    output logic [3*NUM_PLAYERS-1:0] move,
    output logic [NUM_PLAYERS-1:0]   dir_changed
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [4*NUM_PLAYERS-1:0]   press;
    dir_t [NUM_PLAYERS-1:0]     cand;
    logic [NUM_PLAYERS-1:0]     cand_ok;
    dir_t [NUM_PLAYERS-1:0]     move_q;
    dir_t [NUM_PLAYERS-1:0]     pend_q;
    logic [NUM_PLAYERS-1:0]     pend_valid_q;
    logic [CntW-1:0]            tick_cnt_q;

    for (genvar g = 0; g < 4 * NUM_PLAYERS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(btn[g]),
            .press  (press[g])
        );
    end

`ifdef SNAKE_PS2_DIR_EN
    logic       ps2_skip_q;
    dir_t [3:0] ps2_dir;

    always_comb begin
        ps2_dir = {4{DIR_NONE}};
        if (ps2_key_pressed && !ps2_skip_q) begin
            case (ps2_out)
                PS2_KEY_W: ps2_dir[0] = DIR_UP;
                PS2_KEY_D: ps2_dir[0] = DIR_RIGHT;
                PS2_KEY_S: ps2_dir[0] = DIR_DOWN;
                PS2_KEY_A: ps2_dir[0] = DIR_LEFT;
                PS2_KEY_I: ps2_dir[1] = DIR_UP;
                PS2_KEY_L: ps2_dir[1] = DIR_RIGHT;
                PS2_KEY_K: ps2_dir[1] = DIR_DOWN;
                PS2_KEY_J: ps2_dir[1] = DIR_LEFT;
                default:   ;
            endcase
        end
    end
`endif

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            cand[p] = DIR_NONE;
            if (press[4*p+3])      cand[p] = DIR_UP;
            else if (press[4*p+2]) cand[p] = DIR_RIGHT;
            else if (press[4*p+1]) cand[p] = DIR_DOWN;
            else if (press[4*p])   cand[p] = DIR_LEFT;
`ifdef SNAKE_PS2_DIR_EN
            else                   cand[p] = ps2_dir[p];
`endif
            // Judged against the committed move only, so a pending value never blocks a press.
            cand_ok[p] = (cand[p] != DIR_NONE) && (cand[p] != move_q[p]) &&
                         !((move_q[p] != DIR_NONE) && (cand[p] == dir_reverse(move_q[p])));
        end
    end

    assign tick        = !pause && (tick_cnt_q == CntMax);
    assign dir_changed = pend_valid_q & {NUM_PLAYERS{tick}};
    assign move        = move_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            move_q       <= {NUM_PLAYERS{DIR_NONE}};
            pend_q       <= {NUM_PLAYERS{DIR_NONE}};
            pend_valid_q <= '0;
`ifdef SNAKE_PS2_DIR_EN
            ps2_skip_q   <= 1'b0;
`endif
        end else begin
            if (!pause) begin
                tick_cnt_q <= (tick_cnt_q == CntMax) ? '0 : tick_cnt_q + 1'b1;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (tick && pend_valid_q[p]) begin
                    move_q[p]       <= pend_q[p];
                    pend_valid_q[p] <= 1'b0;
                end
                // A press landing on the tick cycle becomes the next pending value.
                if (cand_ok[p]) begin
                    pend_q[p]       <= cand[p];
                    pend_valid_q[p] <= 1'b1;
                end
            end
`ifdef SNAKE_PS2_DIR_EN
            if (ps2_key_pressed) begin
                ps2_skip_q <= ps2_skip_q ? 1'b0 : (ps2_out == PS2_BREAK);
            end
`endif
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised and directed bench for snake_dir_ctrl against a behavioural direction model.
module tb_snake_dir_ctrl;

    localparam int NP = 2;
    localparam int DB = 4;
    localparam int TD = 10;

    logic            clock = 1'b0;
    logic            reset;
    logic [4*NP-1:0] btn;
    logic            pause;
    logic            tick;
    logic [3*NP-1:0] move;
    logic [NP-1:0]   dir_changed;
`ifdef SNAKE_PS2_DIR_EN
    logic            ps2_key_pressed;
    logic [7:0]      ps2_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    snake_dir_ctrl #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV       (TD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .btn            (btn),
        .pause          (pause),
`ifdef SNAKE_PS2_DIR_EN
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out),
`endif
        .tick           (tick),
        .move           (move),
        .dir_changed    (dir_changed)
    );

    // Behavioural model: a button's accepted level follows the synchronised level once that level
    // has stayed unchanged for DB cycles; a press is seen one cycle after the level rises.
    int m_cnt;
    int m_move [NP];
    int m_pend [NP];
    bit m_pv   [NP];
    bit m_s1   [4*NP];
    bit m_s2   [4*NP];
    bit m_deb  [4*NP];
    bit m_rose [4*NP];
    bit m_evt  [4*NP];
    int m_age  [4*NP];

    always @(posedge clock) begin : model
        bit t;
        int cand;
        bit ok;
        bit s2_next;
        if (reset) begin
            m_cnt = 0;
            for (int p = 0; p < NP; p++) begin
                m_move[p] = 5;
                m_pend[p] = 5;
                m_pv[p]   = 0;
            end
            for (int b = 0; b < 4 * NP; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_rose[b] = 0; m_evt[b] = 0; m_age[b] = 0;
            end
        end else begin
            t = !pause && (m_cnt == TD - 1);
            for (int p = 0; p < NP; p++) begin
                cand = 0;
                for (int k = 0; k < 4; k++) if (cand == 0 && m_evt[4*p+3-k]) cand = k + 1;
                ok = (cand != 0) && (cand != m_move[p]) &&
                     !(m_move[p] != 5 && cand == ((m_move[p] + 1) % 4) + 1);
                if (t && m_pv[p]) begin
                    m_move[p] = m_pend[p];
                    m_pv[p]   = 0;
                end
                if (ok) begin
                    m_pend[p] = cand;
                    m_pv[p]   = 1;
                end
            end
            if (!pause) m_cnt = (m_cnt + 1) % TD;
            for (int b = 0; b < 4 * NP; b++) begin
                m_evt[b]  = m_rose[b];
                m_rose[b] = 0;
                if (m_s2[b] != m_deb[b] && m_age[b] >= DB) begin
                    m_deb[b]  = m_s2[b];
                    m_rose[b] = m_s2[b];
                end
                s2_next  = m_s1[b];
                m_age[b] = (s2_next == m_s2[b]) ? m_age[b] + 1 : 1;
                m_s2[b]  = s2_next;
                m_s1[b]  = btn[b];
            end
        end
    end

    function automatic logic [8:0] model_out();
        logic t;
        t = !pause && (m_cnt == TD - 1);
        return {t, t && m_pv[1], t && m_pv[0], 3'(m_move[1]), 3'(m_move[0])};
    endfunction

    // Press the buttons in mask for 8 cycles, then let the result settle past at least two ticks.
    task automatic press_btn(input logic [4*NP-1:0] mask, output int dc_seen);
        dc_seen = 0;
        btn = btn | mask;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL press cycle %0d: dut=%h model=%h", i, {tick, dir_changed, move},
                         model_out());
            end
            if (dir_changed != 0) dc_seen++;
            if (i == 7) btn = btn & ~mask;
        end
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b1;
        btn   = '0;
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== 9'h02D) begin
                n_fail++;
                $display("FAIL reset state: dut=%h want=%h", {tick, dir_changed, move}, 9'h02D);
            end
        end
        reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL after reset cycle %0d: dut=%h model=%h", i,
                         {tick, dir_changed, move}, model_out());
            end
            if (tick && first < 0) first = i;
        end
        n_checks++;
        if (first !== TD - 1) begin
            n_fail++;
            $display("FAIL first tick: got cycle %0d want %0d", first, TD - 1);
        end
    endtask

    task automatic test_basic_commit();
        int seen;
        int dc01;
        seen = 0;
        dc01 = 0;
        btn[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL basic cycle %0d: dut=%h model=%h", i, {tick, dir_changed, move},
                         model_out());
            end
            if (dir_changed != 0) seen++;
            if (tick && dir_changed == 2'b01) dc01++;
            if (i == 19) btn[3] = 1'b0;
        end
        n_checks++;
        if (move[2:0] !== 3'd1 || seen !== 1 || dc01 !== 1) begin
            n_fail++;
            $display("FAIL basic commit: move0=%0d pulses=%0d tick_pulses=%0d want 1/1/1",
                     move[2:0], seen, dc01);
        end
    endtask

    task automatic test_reversal();
        int dc;
        press_btn(8'h02, dc);
        n_checks++;
        if (move[2:0] !== 3'd1 || dc !== 0) begin
            n_fail++;
            $display("FAIL reversal down: move0=%0d pulses=%0d want 1/0", move[2:0], dc);
        end
        press_btn(8'h04, dc);
        n_checks++;
        if (move[2:0] !== 3'd2 || dc !== 1) begin
            n_fail++;
            $display("FAIL reversal right: move0=%0d pulses=%0d want 2/1", move[2:0], dc);
        end
    endtask

    task automatic test_bounce_priority();
        int dc;
        dc = 0;
        for (int i = 0; i < 37; i++) begin
            btn[3] = (i < 12) && ((i / 2) % 2 == 0);
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: dut=%h model=%h", i, {tick, dir_changed, move},
                         model_out());
            end
            if (dir_changed != 0) dc++;
        end
        n_checks++;
        if (move[2:0] !== 3'd2 || dc !== 0) begin
            n_fail++;
            $display("FAIL bounce: move0=%0d pulses=%0d want 2/0", move[2:0], dc);
        end
        press_btn(8'h90, dc);
        n_checks++;
        if (move[5:3] !== 3'd1 || move[2:0] !== 3'd2) begin
            n_fail++;
            $display("FAIL priority: move1=%0d move0=%0d want 1/2", move[5:3], move[2:0]);
        end
    endtask

    task automatic test_last_wins_pause();
        int dc;
        int ticks;
        int first;
        bit found;
        press_btn(8'h08, dc);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (tick) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL last-wins tick wait: no tick within 20 cycles");
        end
        // Right then left one cycle apart, both landing inside the same tick period.
        btn[2] = 1'b1;
        dc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL last-wins cycle %0d: dut=%h model=%h", i,
                         {tick, dir_changed, move}, model_out());
            end
            if (dir_changed[0]) dc++;
            if (i == 0) btn[0] = 1'b1;
            if (i == 5) btn[2] = 1'b0;
            if (i == 6) btn[0] = 1'b0;
        end
        n_checks++;
        if (move[2:0] !== 3'd4 || dc !== 1) begin
            n_fail++;
            $display("FAIL last-wins: move0=%0d pulses=%0d want 4/1", move[2:0], dc);
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (tick) found = 1;
        end
        @(negedge clock);
        pause = 1'b1;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (tick) ticks++;
        end
        n_checks++;
        if (!found || ticks !== 0 || move !== 6'o14) begin
            n_fail++;
            $display("FAIL pause: found=%0d ticks=%0d move=%o want 1/0/14", found, ticks, move);
        end
        pause = 1'b0;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL unpause cycle %0d: dut=%h model=%h", i,
                         {tick, dir_changed, move}, model_out());
            end
            if (tick && first < 0) first = i;
        end
        n_checks++;
        if (first !== TD - 1) begin
            n_fail++;
            $display("FAIL pause resume: first tick at %0d want %0d", first, TD - 1);
        end
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL random cycle %0d: dut=%h model=%h btn=%h", i,
                         {tick, dir_changed, move}, model_out(), btn);
            end
            if (i < 580) begin
                if ($urandom_range(5) == 0) begin
                    b = $urandom_range(4 * NP - 1);
                    btn[b] = ~btn[b];
                end
                if ($urandom_range(24) == 0) pause = ~pause;
            end else begin
                btn   = '0;
                pause = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        int dc;
        press_btn(8'h80, dc);
        btn[6] = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({tick, dir_changed, move} !== 9'h02D) begin
            n_fail++;
            $display("FAIL mid reset: dut=%h want=%h", {tick, dir_changed, move}, 9'h02D);
        end
        reset  = 1'b0;
        btn[6] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL post reset cycle %0d: dut=%h model=%h", i,
                         {tick, dir_changed, move}, model_out());
            end
        end
    endtask

`ifdef SNAKE_PS2_DIR_EN
    task automatic test_ps2();
        int dc;
        logic [7:0] seq [3];
        seq[0] = 8'h1C;
        seq[1] = 8'hF0;
        seq[2] = 8'h1C;
        press_btn(8'h08, dc);
        press_btn(8'h04, dc);
        dc = 0;
        for (int k = 0; k < 3; k++) begin
            ps2_out         = seq[k];
            ps2_key_pressed = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                ps2_key_pressed = 1'b0;
                if (dir_changed != 0) dc++;
            end
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tick, dir_changed, move} !== model_out()) begin
                n_fail++;
                $display("FAIL ps2 cycle %0d: dut=%h model=%h", i, {tick, dir_changed, move},
                         model_out());
            end
            if (dir_changed != 0) dc++;
        end
        n_checks++;
        if (move[2:0] !== 3'd2 || dc !== 0) begin
            n_fail++;
            $display("FAIL ps2 reverse: move0=%0d pulses=%0d want 2/0", move[2:0], dc);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        btn   = '0;
        pause = 1'b0;
`ifdef SNAKE_PS2_DIR_EN
        ps2_key_pressed = 1'b0;
        ps2_out         = 8'h00;
`endif
        test_reset();
        test_basic_commit();
        test_reversal();
        test_bounce_priority();
        test_last_wins_pause();
        test_random();
        test_mid_reset();
`ifdef SNAKE_PS2_DIR_EN
        test_ps2();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
